reg_file_2r1w: RTL

//   MIPS register file at the far end of the 5-bit destination-register select path.
//   - Consumes the selected write-register index and write-back data from the WB stage.
//   - Serves two read ports to ID: rs and rt.
//   - Holds NUM_REGS registers; register 0 is hardwired to zero.
//   - One clock domain; the only sequential state is the register array.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_read_port.sv | 40 ++++
 rtl/reg_file_2r1w.sv | 56 +++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, index/word types and the hardwired-zero index for the MIPS register file.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: index mux, zero-index force and, with REGFILE_BYPASS_EN
// defined, a same-cycle write-through from the write-back port.
module reg_read_port
  import regfile_pkg::*;
(
  input  reg_idx_t  rd_idx,
  input  reg_word_t regs [NUM_REGS],
  input  logic      wr_en,
  input  reg_idx_t  wr_idx,
  input  reg_word_t wr_data,
  output reg_word_t rd_data
);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = wr_en && (wr_idx != REG_ZERO) && (wr_idx == rd_idx);
`else
  logic bypass_hit;
  logic unused_bypass;
  assign bypass_hit    = 1'b0;
  assign unused_bypass = ^{wr_en, wr_idx, wr_data};
`endif

  always_comb begin
    rd_data = regs[rd_idx];
    if (rd_idx == REG_ZERO) begin
      rd_data = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (bypass_hit) begin
      rd_data = wr_data;
    end
`else
    if (bypass_hit) begin
      rd_data = '0;
    end
`endif
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// MIPS register file, two combinational read ports (rs/rt), one write port, debug read.
// Optional same-cycle write-through on the rs/rt ports when REGFILE_BYPASS_EN is defined.
module reg_file_2r1w
  import regfile_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET,
  input  reg_idx_t  READ_REG1,
  input  reg_idx_t  READ_REG2,
  input  logic      REG_WRITE,
  input  reg_idx_t  WRITE_REG,
  input  reg_word_t WRITE_DATA,
  output reg_word_t READ_DATA1,
  output reg_word_t READ_DATA2,
  input  reg_idx_t  DBG_ADDR,
  output reg_word_t DBG_DATA
);

  reg_word_t regs [NUM_REGS];
  logic      wr_live;

  // Reset masks the bypass too, so every output reads zero while RESET is high.
  assign wr_live = REG_WRITE && !RESET;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (REG_WRITE && (WRITE_REG != REG_ZERO)) begin
      regs[WRITE_REG] <= WRITE_DATA;
    end
  end

  reg_read_port u_port_rs (
    .rd_idx  (READ_REG1),
    .regs    (regs),
    .wr_en   (wr_live),
    .wr_idx  (WRITE_REG),
    .wr_data (WRITE_DATA),
    .rd_data (READ_DATA1)
  );

  reg_read_port u_port_rt (
    .rd_idx  (READ_REG2),
    .regs    (regs),
    .wr_en   (wr_live),
    .wr_idx  (WRITE_REG),
    .wr_data (WRITE_DATA),
    .rd_data (READ_DATA2)
  );

  // Entry 0 is never written, so a plain index already returns zero there.
  assign DBG_DATA = regs[DBG_ADDR];

endmodule
